// File: rtl/cla_seq_ctrl_if.sv
// Handshake and operand/result bundle for the sequential 16-bit CLA adder.
// The ovf signal exists only when CLA_SEQ_OVF_EN is defined.
interface cla_seq_ctrl_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
`ifdef CLA_SEQ_OVF_EN
  logic        ovf;
`endif

`ifdef CLA_SEQ_OVF_EN
  modport master (output start, a, b, cin, input ready, busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output ready, busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input ready, busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output ready, busy, done, sum, cout);
`endif
endinterface

// File: rtl/cla_seq_ctrl.sv
// Sequential 16-bit adder that pushes one nibble per cycle through a shared 4-bit CLA slice.
// Optional signed-overflow output is enabled by defining CLA_SEQ_OVF_EN.
module cla_seq_ctrl (
  input  logic           clk,
  input  logic           rst,
  cla_seq_ctrl_if.slave  io
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic [15:0] a_q, b_q, sum_q;
  logic        carry_q;
  logic [1:0]  cnt_q;
  logic        ready_q, busy_q, done_q, cout_q;
`ifdef CLA_SEQ_OVF_EN
  logic        ovf_q;
`endif

  logic [3:0] nib_a, nib_b, g, p, nib_sum;
  logic [4:0] c;

  assign nib_a = a_q[{cnt_q, 2'b00} +: 4];
  assign nib_b = b_q[{cnt_q, 2'b00} +: 4];
  assign g     = nib_a & nib_b;
  assign p     = nib_a ^ nib_b;

  // All nibble carries are formed directly from the registered carry-in.
  assign c[0] = carry_q;
  assign c[1] = g[0] | (p[0] & carry_q);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & carry_q);
  assign nib_sum = p ^ c[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (io.start) begin
            a_q     <= io.a;
            b_q     <= io.b;
            carry_q <= io.cin;
            cnt_q   <= '0;
            state_q <= BUSY;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        BUSY: begin
          sum_q[{cnt_q, 2'b00} +: 4] <= nib_sum;
          carry_q <= c[4];
          cnt_q   <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            cout_q  <= c[4];
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= c[3] ^ c[4];
`endif
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign io.ready = ready_q;
  assign io.busy  = busy_q;
  assign io.done  = done_q;
  assign io.sum   = sum_q;
  assign io.cout  = cout_q;
`ifdef CLA_SEQ_OVF_EN
  assign io.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Scoreboard bench for cla_seq_ctrl: a cycle-level acceptance model predicts results and done timing.
module tb_cla_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cla_seq_ctrl_if bus ();

  cla_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;
  int   rem   = 0;   // edges left before the adder can accept again

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endfunction

  // Reference model: an accepted add completes exactly 4 edges later with a+b+cin.
  initial begin
    forever begin
      @(posedge clk);
      cycle++;
      if (rst) rem = 0;
      else if (rem > 0) rem--;
      else if (bus.start) begin
        exp_t e;
        logic [16:0] full;
        full   = {1'b0, bus.a} + {1'b0, bus.b} + {16'd0, bus.cin};
        e.sum  = full[15:0];
        e.cout = full[16];
        e.ovf  = (bus.a[15] == bus.b[15]) && (full[15] != bus.a[15]);
        e.cyc  = cycle + 4;
        q.push_back(e);
        rem = 4;
      end
    end
  end

  // Monitor: compares outputs away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].cyc == cycle) begin
        chk("done_pulse", {31'd0, bus.done}, 32'd1);
        chk("sum", {16'd0, bus.sum}, {16'd0, q[0].sum});
        chk("cout", {31'd0, bus.cout}, {31'd0, q[0].cout});
`ifdef CLA_SEQ_OVF_EN
        chk("ovf", {31'd0, bus.ovf}, {31'd0, q[0].ovf});
`endif
        void'(q.pop_front());
      end else begin
        chk("no_done", {31'd0, bus.done}, 32'd0);
      end
      chk("ready", {31'd0, bus.ready}, {31'd0, rem == 0});
      chk("busy", {31'd0, bus.busy}, {31'd0, rem != 0});
    end
  end

  task automatic op(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    @(negedge clk);
    bus.a = ta; bus.b = tb; bus.cin = tc; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (q.size() > 0 || rem != 0); i++) @(negedge clk);
    chk("drain_timeout", q.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_sum", {16'd0, bus.sum}, 32'd0);
    chk("rst_cout", {31'd0, bus.cout}, 32'd0);
`ifdef CLA_SEQ_OVF_EN
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();

    // Start on the very first edge after reset release.
    @(negedge clk);
    rst = 1'b0;
    bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    op(16'hFFFF, 16'h0001, 1'b0); drain();
    op(16'h7FFF, 16'h0001, 1'b0); drain();
    op(16'h8000, 16'h8000, 1'b0); drain();

    // Start during BUSY must be ignored, operands may change freely.
    op(16'h00FF, 16'h0001, 1'b0);
    bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h5555;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 16'h0000; bus.b = 16'hFFFF; bus.cin = 1'b1;
    drain();

    // Abort in the second BUSY cycle.
    op(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    q.delete();
    rem = 0;
    #1 check_reset_outputs();
    @(negedge clk);
    #1 rst = 1'b0;
    op(16'h0001, 16'h0001, 1'b1); drain();

    // Continuous start: back-to-back ops every 5 cycles.
    @(negedge clk);
    bus.a = 16'h0F0F; bus.b = 16'h00F1; bus.cin = 1'b0; bus.start = 1'b1;
    repeat (22) @(negedge clk);
    bus.start = 1'b0;
    drain();

    // Random traffic, including starts that land in BUSY.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.a     = 16'($urandom);
      bus.b     = 16'($urandom);
      bus.cin   = 1'($urandom_range(0, 1));
      bus.start = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_seq_ctrl.md
CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1: request a 16-bit add; sampled on the rising clk edge.
REQ-004 SHALL have port a, input, 16: operand A.
REQ-005 SHALL have port b, input, 16: operand B.
REQ-006 SHALL have port cin, input, 1: carry-in to bit 0.
REQ-007 SHALL have port ready, output, 1: high when start will be accepted.
REQ-008 SHALL have port busy, output, 1: high while nibbles are being processed.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when the result is valid.
REQ-010 SHALL have port sum, output, 16: result register.
REQ-011 SHALL have port cout, output, 1: carry out of bit 15.
REQ-012 SHALL have port ovf, output, 1: signed overflow; present only under CLA_SEQ_OVF_EN.

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY and DONE; all outputs SHALL be registered.
REQ-014 SHALL accept start only in IDLE or DONE, and SHALL ignore start in BUSY, with no effect on the operation in progress.
REQ-015 On the accepting edge, the block SHALL latch a, b and cin into internal registers, clear the 2-bit nibble counter, and enter BUSY; later changes on a, b and cin SHALL have no effect.
REQ-016 In BUSY, each edge SHALL process one 4-bit nibble, LSB nibble first, through a single shared 4-bit carry-lookahead slice.
  - Per bit: g = a&b, p = a^b.
  - Nibble carries are formed by lookahead from the registered carry, with no ripple chain.
  - sum[4k+3:4k] is written from the slice.
  - The nibble carry-out is stored for the next nibble.
REQ-017 The nibble counter SHALL increment 0 to 3; on the edge processing nibble 3 the FSM SHALL go to DONE, load cout, and set done=1.
REQ-018 Latency: done SHALL be high during the cycle after the 4th rising edge following the accepting edge, for exactly one cycle.
REQ-019 In DONE with no start, the FSM SHALL return to IDLE on the next edge; with start, it SHALL re-enter BUSY directly, giving back-to-back operations with a 5-cycle period.
REQ-020 ready SHALL be 1 in IDLE and DONE and 0 in BUSY; busy SHALL equal NOT ready.
REQ-021 sum, cout and ovf SHALL hold their last result until the next accepting edge.
REQ-022 Arithmetic SHALL be modulo 2^16 with cout = bit 16 of a + b + cin.

Reset
REQ-023 Asserting rst SHALL immediately, independent of clk, force state to IDLE and clear the counter and internal registers; it SHALL also force sum, cout, ovf and done to 0, busy to 0 and ready to 1.
REQ-024 rst asserted mid-operation SHALL abort it; no done pulse SHALL be emitted for the aborted operation.
REQ-025 start sampled on the first edge after rst deasserts SHALL be accepted.

Configuration
REQ-026 With macro CLA_SEQ_OVF_EN defined:
  - port ovf SHALL exist.
  - ovf SHALL be loaded with (carry into bit 15) XOR (carry out of bit 15) on the same edge as cout.
  - ovf SHALL reset to 0.
REQ-027 Without CLA_SEQ_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 a=0x1234, b=0x4321, cin=0, start pulse -> done 4 edges later, sum=0x5555, cout=0.
REQ-029 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, with the carry propagating across all four nibbles; if CLA_SEQ_OVF_EN, ovf=0.
REQ-030 With CLA_SEQ_OVF_EN: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-031 Start 0x00FF+0x0001; during BUSY, pulse start with a=0xAAAA and change a and b -> a single done, sum=0x0100, busy low only after it.
REQ-032 Assert rst on the 2nd BUSY cycle -> all outputs reset immediately, no done, ready=1; a new start of 0x0001+0x0001+cin=1 -> sum=0x0003.
REQ-033 Hold start high continuously with a=0x0F0F, b=0x00F1, cin=0 -> done pulses every 5 cycles, each with sum=0x1000, cout=0.
